// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage. Takes the EX/MEM latch, runs loads and
// stores over a request/ready data bus, and registers the result toward WB.
// Handles byte-lane steering, sign/zero extension, alignment checks, a bus
// timeout, and the mem_stall back-pressure that holds the upstream stages.
//
// Bus handshake: while dmem_req is high, dmem_addr/dmem_we/dmem_wdata/dmem_be
// are held stable. The transfer completes at the first rising edge where
// dmem_ready is high. dmem_ready is ignored whenever dmem_req is low.
`timescale 1ns/1ps
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] read_data_2_in,
  input  logic [4:0]  write_register_in,
  input  logic        reg_write_in,
  input  logic        mem_to_reg_in,
  input  logic        is_halt_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [5:0]  opcode_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] mem_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  write_register_out,
  output logic        reg_write_out,
  output logic        mem_to_reg_out,
  output logic        is_halt_out,
  output logic        misalign_out,
  output logic        bus_error_out,
  output logic        fsm_state
);

  localparam logic [0:0]  ST_IDLE     = 1'b0;
  localparam logic [0:0]  ST_ACCESS   = 1'b1;
  localparam logic [1:0]  SZ_BYTE     = 2'd0;
  localparam logic [1:0]  SZ_HALF     = 2'd1;
  localparam logic [1:0]  SZ_WORD     = 2'd2;
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
  localparam bit          TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

  logic [0:0]  state;
  logic [15:0] wait_cnt;

  // Access captured at IDLE -> ACCESS; upstream is held, but keeping our own
  // copy makes the bus fields immune to anything upstream does meanwhile.
  logic [31:0] addr_q, wdata_q, alu_q;
  logic [3:0]  be_q;
  logic [1:0]  size_q, off_q;
  logic        we_q, sign_q;
  logic [4:0]  wreg_q;
  logic        regw_q, m2r_q, halt_q;

  logic [1:0]  a;
  logic        is_mem, misalign, mis_op, start_access, in_access, done, timeout_hit;
  logic [1:0]  size_d;
  logic        sign_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, load_ext;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign a      = alu_result_in[1:0];
  assign is_mem = mem_read_in | mem_write_in;

  // Access size and signedness from the opcode; unknown opcodes act as words.
  always_comb begin
    size_d = SZ_WORD;
    sign_d = 1'b0;
    case (opcode_in)
      6'h20:        begin size_d = SZ_BYTE; sign_d = 1'b1; end
      6'h24, 6'h28: size_d = SZ_BYTE;
      6'h21:        begin size_d = SZ_HALF; sign_d = 1'b1; end
      6'h25, 6'h29: size_d = SZ_HALF;
      default:      size_d = SZ_WORD;
    endcase
  end

  // Lane enables, replicated store data and alignment check per access size.
  always_comb begin
    be_d     = 4'b1111;
    wdata_d  = read_data_2_in;
    misalign = 1'b0;
    case (size_d)
      SZ_BYTE: begin
        be_d    = 4'b0001 << a;
        wdata_d = {4{read_data_2_in[7:0]}};
      end
      SZ_HALF: begin
        be_d     = a[1] ? 4'b1100 : 4'b0011;
        wdata_d  = {2{read_data_2_in[15:0]}};
        misalign = a[0];
      end
      default: misalign = (a != 2'b00);
    endcase
  end

  assign mis_op       = is_mem & misalign;
  assign start_access = (state == ST_IDLE) & is_mem & ~misalign;
  assign in_access    = (state == ST_ACCESS);
  assign done         = in_access & dmem_ready;
  // Fires on the TIMEOUT_CYCLES-th ACCESS cycle that still sees no ready.
  assign timeout_hit  = TIMEOUT_EN && in_access && !dmem_ready &&
                        (wait_cnt == TIMEOUT_LIM - 16'd1);

  // Hold upstream for the IDLE cycle of an aligned access and for every wait cycle.
  assign mem_stall = ~reset & ((state == ST_IDLE) ? start_access
                                                   : (~dmem_ready & ~timeout_hit));

  assign dmem_req   = in_access;
  assign dmem_we    = in_access & we_q;
  assign dmem_be    = in_access ? be_q : 4'b0000;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign fsm_state  = state;

  // Pick the addressed lane out of the returned word and extend it.
  always_comb begin
    lane_b   = dmem_rdata[{off_q, 3'b000} +: 8];
    lane_h   = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_ext = dmem_rdata;
    case (size_q)
      SZ_BYTE: load_ext = {{24{sign_q & lane_b[7]}}, lane_b};
      SZ_HALF: load_ext = {{16{sign_q & lane_h[15]}}, lane_h};
      default: load_ext = dmem_rdata;
    endcase
  end

  // FSM, wait counter and capture of the outstanding access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= 16'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      we_q     <= 1'b0;
      size_q   <= SZ_WORD;
      sign_q   <= 1'b0;
      off_q    <= 2'd0;
      alu_q    <= 32'd0;
      wreg_q   <= 5'd0;
      regw_q   <= 1'b0;
      m2r_q    <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_access) begin
            state    <= ST_ACCESS;
            wait_cnt <= 16'd0;
            addr_q   <= {alu_result_in[31:2], 2'b00};
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            we_q     <= mem_write_in;
            size_q   <= size_d;
            sign_q   <= sign_d;
            off_q    <= a;
            alu_q    <= alu_result_in;
            wreg_q   <= write_register_in;
            regw_q   <= reg_write_in;
            m2r_q    <= mem_to_reg_in;
            halt_q   <= is_halt_in;
          end
        end
        default: begin
          if (done || timeout_hit) state <= ST_IDLE;
          else                     wait_cnt <= wait_cnt + 16'd1;
        end
      endcase
    end
  end

  // WB-facing registers: bubble by default, pass-through, completion or abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_data_out       <= 32'd0;
      alu_result_out     <= 32'd0;
      write_register_out <= 5'd0;
      reg_write_out      <= 1'b0;
      mem_to_reg_out     <= 1'b0;
      is_halt_out        <= 1'b0;
      misalign_out       <= 1'b0;
      bus_error_out      <= 1'b0;
    end else begin
      mem_data_out       <= 32'd0;
      alu_result_out     <= 32'd0;
      write_register_out <= 5'd0;
      reg_write_out      <= 1'b0;
      mem_to_reg_out     <= 1'b0;
      is_halt_out        <= 1'b0;
      misalign_out       <= 1'b0;
      bus_error_out      <= 1'b0;
      if (state == ST_IDLE) begin
        if (!start_access) begin
          alu_result_out     <= alu_result_in;
          write_register_out <= write_register_in;
          reg_write_out      <= reg_write_in & ~mis_op;
          mem_to_reg_out     <= mem_to_reg_in & ~mis_op;
          is_halt_out        <= is_halt_in;
          misalign_out       <= mis_op;
        end
      end else if (done) begin
        alu_result_out     <= alu_q;
        write_register_out <= wreg_q;
        reg_write_out      <= regw_q & ~we_q;
        mem_to_reg_out     <= m2r_q & ~we_q;
        is_halt_out        <= halt_q;
        mem_data_out       <= we_q ? 32'd0 : load_ext;
      end else if (timeout_hit) begin
        alu_result_out     <= alu_q;
        write_register_out <= wreg_q;
        is_halt_out        <= halt_q;
        bus_error_out      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed table, randomized ops against a
// reference model, and reset sequences around an outstanding access.
`timescale 1ns/1ps
module tb_mem_access_stage;

  localparam int TO = 4;
  localparam int RW = 74;
  localparam int CW = 160;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_result_in, read_data_2_in;
  logic [4:0]  write_register_in;
  logic        reg_write_in, mem_to_reg_in, is_halt_in, mem_read_in, mem_write_in;
  logic [5:0]  opcode_in;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall;
  logic [31:0] mem_data_out, alu_result_out;
  logic [4:0]  write_register_out;
  logic        reg_write_out, mem_to_reg_out, is_halt_out, misalign_out, bus_error_out;
  logic        fsm_state;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .alu_result_in(alu_result_in), .read_data_2_in(read_data_2_in),
    .write_register_in(write_register_in), .reg_write_in(reg_write_in),
    .mem_to_reg_in(mem_to_reg_in), .is_halt_in(is_halt_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .opcode_in(opcode_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_data_out(mem_data_out),
    .alu_result_out(alu_result_out), .write_register_out(write_register_out),
    .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
    .is_halt_out(is_halt_out), .misalign_out(misalign_out),
    .bus_error_out(bus_error_out), .fsm_state(fsm_state)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // ---------------- vectors / scoreboard ----------------
  typedef struct {
    logic [5:0]  op;
    logic        rd, wr;
    logic [31:0] addr, rt;
    logic        rw;
    logic [4:0]  wreg;
    logic        m2r, halt;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] e_data;
    logic        e_rw, e_m2r, e_mis, e_berr;
    int          e_req, e_stall;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_wdata;
  } vec_t;

  int total  = 0;
  int passed = 0;
  logic [RW-1:0] exp_q[$];
  vec_t tbl[17];
  logic [5:0] op_list[11] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h27,
                              6'h28, 6'h29, 6'h2B, 6'h00, 6'h30};

  task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else passed++;
  endtask

  function automatic vec_t mkv(
    input logic [5:0] op, input logic rd, input logic wr, input logic [31:0] addr,
    input logic [31:0] rt, input logic rw, input logic [4:0] wreg, input logic m2r,
    input logic halt, input logic [31:0] rdata, input int waits,
    input logic [31:0] e_data, input logic e_rw, input logic e_m2r, input logic e_mis,
    input logic e_berr, input int e_req, input int e_stall, input logic [31:0] e_addr,
    input logic [3:0] e_be, input logic e_we, input logic [31:0] e_wdata);
    vec_t v;
    v.op = op; v.rd = rd; v.wr = wr; v.addr = addr; v.rt = rt; v.rw = rw;
    v.wreg = wreg; v.m2r = m2r; v.halt = halt; v.rdata = rdata; v.waits = waits;
    v.e_data = e_data; v.e_rw = e_rw; v.e_m2r = e_m2r; v.e_mis = e_mis;
    v.e_berr = e_berr; v.e_req = e_req; v.e_stall = e_stall; v.e_addr = e_addr;
    v.e_be = e_be; v.e_we = e_we; v.e_wdata = e_wdata;
    return v;
  endfunction

  // Reference model: expectations from the access rules with plain arithmetic.
  function automatic vec_t ref_model(input vec_t v);
    vec_t r;
    int n, a;
    logic [31:0] mask, lane, rep;
    r = v;
    n = (v.op == 6'h20 || v.op == 6'h24 || v.op == 6'h28) ? 1 :
        (v.op == 6'h21 || v.op == 6'h25 || v.op == 6'h29) ? 2 : 4;
    a = int'(v.addr % 32'd4);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    rep  = (n == 1) ? 32'h0101_0101 : (n == 2) ? 32'h0001_0001 : 32'h1;
    r.e_data = 32'd0; r.e_rw = v.rw; r.e_m2r = v.m2r; r.e_mis = 1'b0; r.e_berr = 1'b0;
    r.e_req = 0; r.e_stall = 0; r.e_addr = 32'd0; r.e_be = 4'd0; r.e_we = 1'b0; r.e_wdata = 32'd0;
    if (!(v.rd || v.wr)) return r;
    if (a % n != 0) begin
      r.e_rw = 1'b0; r.e_m2r = 1'b0; r.e_mis = 1'b1;
      return r;
    end
    r.e_addr  = v.addr - 32'(a);
    r.e_be    = 4'(((1 << n) - 1) << a);
    r.e_we    = v.wr;
    r.e_wdata = (v.rt & mask) * rep;
    if (v.waits >= TO) begin
      r.e_req = TO; r.e_stall = TO; r.e_rw = 1'b0; r.e_m2r = 1'b0; r.e_berr = 1'b1;
      return r;
    end
    r.e_req = v.waits + 1; r.e_stall = v.waits + 1;
    if (v.wr) begin
      r.e_rw = 1'b0; r.e_m2r = 1'b0;
      return r;
    end
    lane = (v.rdata >> (8 * a)) & mask;
    if ((v.op == 6'h20 || v.op == 6'h21) && lane[8 * n - 1]) lane = lane - (32'd1 << (8 * n));
    r.e_data = lane;
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    int sel;
    v = mkv(6'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.op    = op_list[$urandom_range(0, 10)];
    sel     = $urandom_range(0, 7);
    v.rd    = (sel >= 2 && sel <= 4) || sel == 7;
    v.wr    = (sel >= 5);
    v.addr  = $urandom();
    v.rt    = $urandom();
    v.rdata = $urandom();
    v.rw    = 1'($urandom_range(0, 1));
    v.m2r   = 1'($urandom_range(0, 1));
    v.wreg  = 5'($urandom_range(0, 31));
    v.halt  = ($urandom_range(0, 15) == 0);
    v.waits = $urandom_range(0, 5);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    alu_result_in = 32'd0; read_data_2_in = 32'd0; write_register_in = 5'd0;
    reg_write_in = 1'b0; mem_to_reg_in = 1'b0; is_halt_in = 1'b0;
    mem_read_in = 1'b0; mem_write_in = 1'b0; opcode_in = 6'd0;
  endtask

  task automatic drive_inputs(input vec_t v);
    alu_result_in = v.addr; read_data_2_in = v.rt; write_register_in = v.wreg;
    reg_write_in = v.rw; mem_to_reg_in = v.m2r; is_halt_in = v.halt;
    mem_read_in = v.rd; mem_write_in = v.wr; opcode_in = v.op; dmem_rdata = v.rdata;
  endtask

  // Presents one op (called just after a rising edge), plays the memory
  // responder, and checks bus fields, stall length and the retired result.
  task automatic run_op(input vec_t v);
    int req_cnt, stall_cnt, cyc;
    logic retired, bus_bad, bub_bad, stall_now;
    logic [RW-1:0] exp;
    drive_inputs(v);
    exp_q.push_back({v.e_data, v.addr, v.wreg, v.e_rw, v.e_m2r, v.halt, v.e_mis, v.e_berr});
    req_cnt = 0; stall_cnt = 0; cyc = 0;
    retired = 1'b0; bus_bad = 1'b0; bub_bad = 1'b0;
    while (!retired && cyc < 20) begin
      @(negedge clk);
      if (dmem_req) begin
        req_cnt++;
        dmem_ready = (req_cnt > v.waits);
        if (dmem_addr !== v.e_addr || dmem_be !== v.e_be || dmem_we !== v.e_we ||
            (v.e_we && dmem_wdata !== v.e_wdata)) bus_bad = 1'b1;
      end else begin
        dmem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      stall_now = mem_stall;
      if (stall_now) stall_cnt++;
      @(posedge clk);
      #1;
      cyc++;
      if (!stall_now) retired = 1'b1;
      else if (reg_write_out | mem_to_reg_out | is_halt_out | misalign_out | bus_error_out)
        bub_bad = 1'b1;
    end
    exp = exp_q.pop_front();
    chk("retire_bound", CW'(retired), CW'(1'b1));
    chk("req_cycles", CW'(req_cnt), CW'(v.e_req));
    chk("stall_cycles", CW'(stall_cnt), CW'(v.e_stall));
    if (v.e_req > 0) chk("bus_fields", CW'(bus_bad), CW'(1'b0));
    if (v.e_stall > 0) chk("bubble_while_stalled", CW'(bub_bad), CW'(1'b0));
    chk("retire_result",
        CW'({mem_data_out, alu_result_out, write_register_out, reg_write_out,
             mem_to_reg_out, is_halt_out, misalign_out, bus_error_out}), CW'(exp));
    dmem_ready = 1'b0;
  endtask

  function automatic logic [CW-1:0] all_outs();
    return CW'({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, mem_stall,
                mem_data_out, alu_result_out, write_register_out, reg_write_out,
                mem_to_reg_out, is_halt_out, misalign_out, bus_error_out, fsm_state});
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    vec_t v;
    tbl[0]  = mkv(6'h00, 0, 0, 32'h1234, 0, 1, 5'd3, 0, 0, 0, 0,
                  32'h0, 1, 0, 0, 0, 0, 0, 32'h0, 4'b0000, 0, 32'h0);
    tbl[1]  = mkv(6'h20, 1, 0, 32'h103, 0, 1, 5'd4, 1, 0, 32'h80123456, 2,
                  32'hFFFFFF80, 1, 1, 0, 0, 3, 3, 32'h100, 4'b1000, 0, 32'h0);
    tbl[2]  = mkv(6'h24, 1, 0, 32'h103, 0, 1, 5'd4, 1, 0, 32'h80123456, 2,
                  32'h00000080, 1, 1, 0, 0, 3, 3, 32'h100, 4'b1000, 0, 32'h0);
    tbl[3]  = mkv(6'h29, 0, 1, 32'h202, 32'hAAAA5678, 1, 5'd6, 0, 0, 0, 0,
                  32'h0, 0, 0, 0, 0, 1, 1, 32'h200, 4'b1100, 1, 32'h56785678);
    tbl[4]  = mkv(6'h28, 0, 1, 32'h201, 32'h000000EE, 0, 5'd0, 0, 0, 0, 1,
                  32'h0, 0, 0, 0, 0, 2, 2, 32'h200, 4'b0010, 1, 32'hEEEEEEEE);
    tbl[5]  = mkv(6'h23, 1, 0, 32'h302, 0, 1, 5'd7, 1, 0, 0, 0,
                  32'h0, 0, 0, 1, 0, 0, 0, 32'h0, 4'b0000, 0, 32'h0);
    tbl[6]  = mkv(6'h21, 1, 0, 32'h102, 0, 1, 5'd8, 1, 0, 32'h80017FFF, 0,
                  32'hFFFF8001, 1, 1, 0, 0, 1, 1, 32'h100, 4'b1100, 0, 32'h0);
    tbl[7]  = mkv(6'h25, 1, 0, 32'h100, 0, 1, 5'd9, 1, 0, 32'h1234ABCD, 1,
                  32'h0000ABCD, 1, 1, 0, 0, 2, 2, 32'h100, 4'b0011, 0, 32'h0);
    tbl[8]  = mkv(6'h23, 1, 0, 32'h400, 0, 1, 5'd10, 1, 0, 32'hFFFFFFFF, 99,
                  32'h0, 0, 0, 0, 1, 4, 4, 32'h400, 4'b1111, 0, 32'h0);
    tbl[9]  = mkv(6'h00, 0, 0, 32'hCAFE, 0, 1, 5'd11, 0, 0, 0, 0,
                  32'h0, 1, 0, 0, 0, 0, 0, 32'h0, 4'b0000, 0, 32'h0);
    tbl[10] = mkv(6'h23, 1, 0, 32'h404, 0, 1, 5'd12, 1, 0, 32'h11223344, 3,
                  32'h11223344, 1, 1, 0, 0, 4, 4, 32'h404, 4'b1111, 0, 32'h0);
    tbl[11] = mkv(6'h2B, 1, 1, 32'h500, 32'hDEADBEEF, 1, 5'd13, 1, 0, 32'h55555555, 0,
                  32'h0, 0, 0, 0, 0, 1, 1, 32'h500, 4'b1111, 1, 32'hDEADBEEF);
    tbl[12] = mkv(6'h27, 1, 0, 32'h700, 0, 1, 5'd14, 1, 1, 32'h87654321, 1,
                  32'h87654321, 1, 1, 0, 0, 2, 2, 32'h700, 4'b1111, 0, 32'h0);
    tbl[13] = mkv(6'h30, 1, 0, 32'h601, 0, 1, 5'd15, 1, 0, 0, 0,
                  32'h0, 0, 0, 1, 0, 0, 0, 32'h0, 4'b0000, 0, 32'h0);
    tbl[14] = mkv(6'h30, 1, 0, 32'h600, 0, 1, 5'd16, 0, 0, 32'h0BADF00D, 0,
                  32'h0BADF00D, 1, 0, 0, 0, 1, 1, 32'h600, 4'b1111, 0, 32'h0);
    tbl[15] = mkv(6'h20, 1, 0, 32'h104, 0, 1, 5'd17, 1, 0, 32'hFFFFFF7F, 0,
                  32'h0000007F, 1, 1, 0, 0, 1, 1, 32'h104, 4'b0001, 0, 32'h0);
    tbl[16] = mkv(6'h29, 0, 1, 32'h203, 32'h1234, 1, 5'd18, 0, 0, 0, 0,
                  32'h0, 0, 0, 1, 0, 0, 0, 32'h0, 4'b0000, 0, 32'h0);

    // Power-on reset, with an aligned load presented so the stall gate is exercised.
    drive_idle();
    dmem_ready = 1'b0;
    dmem_rdata = 32'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    opcode_in = 6'h23; mem_read_in = 1'b1; alu_result_in = 32'h10;
    #1;
    chk("reset_state", all_outs(), CW'(0));
    drive_idle();
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", CW'({fsm_state, mem_stall, dmem_req}), CW'(0));
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) run_op(tbl[i]);

    for (int i = 0; i < 150; i++) begin
      v = ref_model(rand_vec());
      run_op(v);
    end

    // Reset in the middle of an outstanding access.
    v = ref_model(mkv(6'h23, 1, 0, 32'h800, 32'h5A5A5A5A, 1, 5'd20, 1, 0, 32'h0, 99,
                      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive_inputs(v);
    dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_reset_access", CW'({dmem_req, mem_stall, dmem_addr}), CW'({2'b11, 32'h800}));
    #2 reset = 1'b1;
    #1;
    chk("reset_mid_access", all_outs(), CW'(0));
    drive_idle();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_after_mid_reset", CW'({fsm_state, mem_stall, dmem_req}), CW'(0));
    @(posedge clk);
    #1;
    run_op(tbl[9]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
